hblur_ctrl: RTL
===============

# hblur_ctrl

Sequencer for the horizontal blur filter. It pulls a raster frame from an upstream valid/ready pixel stream and drives the filter's `wb_en`/`mode_wb`/`data` shift interface. At every row start it primes the 7-deep filter window with 7 copies of the row's first pixel, so no pixels from the previous row leak into the average. It registers the filter's combinational `blur` result into a valid/ready output slot with backpressure, and tracks columns and rows to report frame completion.

## Interface
Parameters:
- `IMG_W`, 640, pixels per row (≥1)
- `IMG_H`, 480, rows per frame (≥1)

Ports:
- `clk` in 1: sole clock, rising edge
- `n_rst` in 1: reset, synchronous, active-low
- `start` in 1: frame start pulse; ignored unless in IDLE
- `in_valid` in 1 / `in_ready` out 1 / `in_pixel` in 32: upstream ARGB pixel stream
- `wb_en` out 1: filter shift enable
- `mode_wb` out 3: 3'b101 while `wb_en`=1, else 3'b000
- `filt_data` out 32: pixel presented to the filter
- `filt_blur` in 32: filter's combinational average
- `out_valid` out 1 / `out_ready` in 1 / `out_pixel` out 32: blurred stream
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle pulse after the last output of the frame is accepted

## Operation
- States: IDLE, FETCH, PRIME, FIRST, RUN, FLUSH, DONE.
- **IDLE**
  - `start` moves the block to FETCH.
  - Column and row counters are cleared.
- **FETCH**
  - `in_ready`=1.
  - On the handshake, `in_pixel` is latched into the hold register and the block moves to PRIME.
- **PRIME**
  - 7 cycles, `prime_cnt` counts 0..6.
  - `wb_en`=1 and `filt_data`=hold on each cycle.
  - No handshakes.
  - After count 6, the block moves to FIRST.
- **FIRST**
  - When the output slot is free (`!out_valid || out_ready`): `wb_en`=1, `filt_data`=hold, `out_pixel`<=`filt_blur`, `out_valid`<=1, col=1.
  - If `IMG_W`==1, go to the end-of-row decision. Otherwise go to RUN.
- **RUN**
  - `in_ready` = slot free.
  - On the handshake: `wb_en`=1, `filt_data`=`in_pixel`, `out_pixel`<=`filt_blur`, `out_valid`<=1, col++.
  - When col reaches `IMG_W`, go to the end-of-row decision.
- **End of row**
  - row++ and col is cleared.
  - If row < `IMG_H`, go to FETCH. Otherwise go to FLUSH.
- **FLUSH**: wait until the output slot drains (`out_valid`=0 or `out_ready`=1), then go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- Output slot:
  - `out_valid` clears on `out_ready` unless it is reloaded in the same cycle.
  - The slot is never overwritten while `out_valid && !out_ready`.
- Arithmetic is inside the filter; the controller passes 32-bit words unmodified and never alters alpha.

## Timing
- Reset (`n_rst`=0 at a clock edge) values: state=IDLE, `out_valid`=0, `out_pixel`=0, `in_ready`=0, `wb_en`=0, `mode_wb`=0, `filt_data`=0, `busy`=0, `done`=0, all counters 0.
- Reset mid-frame aborts the frame and does not pulse `done`.
- The filter's internal window is not cleared by this block; PRIME makes that unnecessary.
- Per-row overhead: 1 FETCH cycle + 7 PRIME cycles, then the first output appears 1 cycle after FIRST.
- RUN latency: input handshake at cycle N gives `out_valid` at N+1.
- RUN throughput: 1 pixel/cycle with `out_ready` held high.
- `wb_en` is asserted in exactly `IMG_W`+7 cycles per row.
- The filter's sum is sampled in the same cycle that `wb_en` shifts (the sum is combinational on `filt_data`).
- `start` while busy: no effect.
- `start` in the same cycle as the DONE pulse: ignored, because the block is not yet in IDLE.

## Configuration
- Macro: `HBLUR_CTRL_BYPASS_EN`.
- When defined:
  - An extra input `bypass` (1 bit) is sampled at `start`.
  - If `bypass` was 1, FETCH/PRIME/FIRST are skipped and rows stream directly in RUN.
  - `out_pixel`<=`in_pixel`, `wb_en` stays 0 for the whole frame, and counters and `done` behave as normal.
- When undefined: no `bypass` port exists, and every frame is filtered.

## Structure
- `hblur_pkg` holds:
  - the state enum `hblur_state_t`;
  - `MODE_HBLUR` = 3'b101;
  - `PRIME_LEN` = 7;
  - `PIX_W` = 32.
- Sub-module `hblur_out_slot`: single-entry valid/ready output register providing `slot_free`, load, and drain.
- The FSM, counters and hold register stay in `hblur_ctrl`.

## Test plan
Filter instantiated with `IMG_W`=4, `IMG_H`=2; pixels are written as R values, with G=B=0 and A=FF.
- **Single row filtering**: row 0 = 8, 16, 24, 32 with `out_ready`=1 → outputs R = 8, 9, 11, 14, each as 0xFF_RR_00_00.
- **Row isolation**: row 1 starts with R=80 → first output R=80 (window contains no row-0 data); `wb_en` count for the row = 11.
- **Backpressure**: hold `out_ready`=0 for 5 cycles mid-row → `in_ready`=0, `out_pixel` stable, no `wb_en`; on release the sequence continues unchanged.
- **Frame end**: `done` pulses exactly once, 1 cycle after the 8th output is accepted; `busy` falls with it; a `start` pulse while busy is ignored.
- **Reset mid-frame**: `n_rst`=0 during PRIME of row 1 → next edge IDLE, `out_valid`=0, no `done`; a new `start` produces a correct full frame.
- **Bypass** (with `HBLUR_CTRL_BYPASS_EN`): `bypass`=1 → outputs equal inputs, `wb_en` never asserted.

Source files
------------

// File: rtl/hblur_pkg.sv
// Shared types and constants for the horizontal blur sequencer.
package hblur_pkg;

  localparam int PIX_W     = 32;
  localparam int PRIME_LEN = 7;

  localparam logic [2:0] MODE_HBLUR = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRIME,
    ST_FIRST,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } hblur_state_t;

endpackage

// File: rtl/hblur_ctrl_if.sv
// Upstream pixel stream and blurred output stream of hblur_ctrl.
interface hblur_ctrl_if;
  import hblur_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;

  modport slave (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel
  );

  modport master (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel
  );

endinterface

// File: rtl/hblur_out_slot.sv
// Single-entry valid/ready output register; load is only honoured when the slot is free.
module hblur_out_slot
  import hblur_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [PIX_W-1:0] load_pixel,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pixel,
  output logic             slot_free
);

  logic             valid_q, valid_d;
  logic [PIX_W-1:0] pixel_q, pixel_d;

  assign slot_free = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    pixel_d = pixel_q;
    if (load && slot_free) begin
      valid_d = 1'b1;
      pixel_d = load_pixel;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      valid_q <= 1'b0;
      pixel_q <= '0;
    end else begin
      valid_q <= valid_d;
      pixel_q <= pixel_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pixel = pixel_q;

endmodule

// File: rtl/hblur_ctrl.sv
// Horizontal blur sequencer: primes the filter window per row, streams pixels, tracks frame end.
// Optional HBLUR_CTRL_BYPASS_EN adds a bypass input that streams pixels unfiltered.
module hblur_ctrl
  import hblur_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
`ifdef HBLUR_CTRL_BYPASS_EN
  input  logic             bypass,
`endif
  hblur_ctrl_if.slave      io,
  output logic             wb_en,
  output logic [2:0]       mode_wb,
  output logic [PIX_W-1:0] filt_data,
  input  logic [PIX_W-1:0] filt_blur,
  output logic             busy,
  output logic             done
);

  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int ROW_W = $clog2(IMG_H + 1);

  hblur_state_t     state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [2:0]       prime_q, prime_d;
  logic [PIX_W-1:0] hold_q, hold_d;
  logic             byp_q, byp_d;

  logic             bypass_in;
  logic             slot_free;
  logic             load;
  logic [PIX_W-1:0] load_pixel;
  logic             in_ready;
  logic             last_col, last_row, eor;

`ifdef HBLUR_CTRL_BYPASS_EN
  assign bypass_in = bypass;
`else
  assign bypass_in = 1'b0;
`endif

  assign last_col = (col_q == COL_W'(IMG_W - 1));
  assign last_row = (row_q == ROW_W'(IMG_H - 1));

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    prime_d    = prime_q;
    hold_d     = hold_q;
    byp_d      = byp_q;
    in_ready   = 1'b0;
    wb_en      = 1'b0;
    filt_data  = '0;
    load       = 1'b0;
    load_pixel = '0;
    done       = 1'b0;
    eor        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        col_d   = '0;
        row_d   = '0;
        prime_d = '0;
        if (start) begin
          byp_d   = bypass_in;
          state_d = bypass_in ? ST_RUN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        in_ready = 1'b1;
        prime_d  = '0;
        if (io.in_valid) begin
          hold_d  = io.in_pixel;
          state_d = ST_PRIME;
        end
      end
      ST_PRIME: begin
        wb_en     = 1'b1;
        filt_data = hold_q;
        prime_d   = prime_q + 3'd1;
        if (prime_q == 3'(PRIME_LEN - 1)) state_d = ST_FIRST;
      end
      ST_FIRST: begin
        // The eighth shift of the row's first pixel is the one whose average is emitted.
        if (slot_free) begin
          wb_en      = 1'b1;
          filt_data  = hold_q;
          load       = 1'b1;
          load_pixel = filt_blur;
          col_d      = COL_W'(1);
          if (last_col) eor = 1'b1;
          else          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        in_ready = slot_free;
        if (slot_free && io.in_valid) begin
          load = 1'b1;
          if (byp_q) begin
            load_pixel = io.in_pixel;
          end else begin
            wb_en      = 1'b1;
            filt_data  = io.in_pixel;
            load_pixel = filt_blur;
          end
          if (last_col) eor = 1'b1;
          else          col_d = col_q + COL_W'(1);
        end
      end
      ST_FLUSH: if (slot_free) state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (eor) begin
      row_d   = row_q + ROW_W'(1);
      col_d   = '0;
      state_d = last_row ? ST_FLUSH : (byp_q ? ST_RUN : ST_FETCH);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      prime_q <= '0;
      hold_q  <= '0;
      byp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      prime_q <= prime_d;
      hold_q  <= hold_d;
      byp_q   <= byp_d;
    end
  end

  hblur_out_slot u_slot (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (load),
    .load_pixel (load_pixel),
    .out_ready  (io.out_ready),
    .out_valid  (io.out_valid),
    .out_pixel  (io.out_pixel),
    .slot_free  (slot_free)
  );

  assign io.in_ready = in_ready;
  assign mode_wb     = wb_en ? MODE_HBLUR : 3'b000;
  assign busy        = (state_q != ST_IDLE);

endmodule
